// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM states and iteration counts for the multiply/divide unit.
// MULDIV_RADIX4_EN selects radix-4 Booth multiply (16 iterations instead of 32).
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef MULDIV_RADIX4_EN
    localparam int MUL_ITER = 16;
`else
    localparam int MUL_ITER = 32;
`endif
    localparam int DIV_ITER = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between datapath control and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Zhigh;
    logic [WIDTH-1:0] Zlow;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (output start, op, A, B,
                    input  Zhigh, Zlow, busy, done, div_zero);
    modport slave  (input  start, op, A, B,
                    output Zhigh, Zlow, busy, done, div_zero);

endinterface

// File: rtl/nr_div_step.sv
// One combinational non-restoring division iteration on unsigned magnitudes.
module nr_div_step #(parameter int WIDTH = 32) (
    input  logic signed [WIDTH+1:0] rem,
    input  logic        [WIDTH-1:0] quo,
    input  logic        [WIDTH-1:0] divisor,
    output logic signed [WIDTH+1:0] rem_nx,
    output logic        [WIDTH-1:0] quo_nx
);

    logic signed [WIDTH+1:0] shifted;
    logic signed [WIDTH+1:0] d_x;

    always_comb begin
        // Partial remainder stays within [-d, d), so dropping its top bit on the shift is safe.
        shifted = {rem[WIDTH:0], quo[WIDTH-1]};
        d_x     = {2'b00, divisor};
        rem_nx  = rem[WIDTH+1] ? (shifted + d_x) : (shifted - d_x);
        quo_nx  = {quo[WIDTH-2:0], ~rem_nx[WIDTH+1]};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (Booth) / divide (non-restoring, sign fix-up) feeding Zhigh/Zlow.
// MULDIV_RADIX4_EN switches the Booth step to radix-4; results are identical either way.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          Clock,
    input logic          clear,
    mul_div_unit_if.slave bus
);

    localparam logic [5:0] MUL_LAST = 6'(MUL_ITER - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITER - 1);

    state_t                  state, state_nx;
    logic [5:0]              cnt;
    logic                    op_r, a_neg, b_neg, q_1;
    logic signed [WIDTH+1:0] hi;
    logic [WIDTH-1:0]        lo, opnd;
    logic [WIDTH-1:0]        zhigh, zlow;
    logic                    dz;
    logic                    last;

    logic signed [WIDTH+1:0] mcand_x, booth_sum, mul_hi_nx;
    logic [WIDTH-1:0]        mul_lo_nx;
    logic                    mul_q1_nx;
    logic signed [WIDTH+1:0] div_rem_nx, div_d_x;
    logic [WIDTH-1:0]        div_quo_nx, div_rem_mag;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign last = (cnt == ((op_r == OP_DIV) ? DIV_LAST : MUL_LAST));

    // Booth step on {hi, lo, q_1}; hi carries guard bits so +/-2A never overflows.
    always_comb begin
        mcand_x = {{2{opnd[WIDTH-1]}}, opnd};
`ifdef MULDIV_RADIX4_EN
        case ({lo[1:0], q_1})
            3'b001, 3'b010: booth_sum = hi + mcand_x;
            3'b011:         booth_sum = hi + (mcand_x <<< 1);
            3'b100:         booth_sum = hi - (mcand_x <<< 1);
            3'b101, 3'b110: booth_sum = hi - mcand_x;
            default:        booth_sum = hi;
        endcase
        mul_hi_nx = booth_sum >>> 2;
        mul_lo_nx = {booth_sum[1:0], lo[WIDTH-1:2]};
        mul_q1_nx = lo[1];
`else
        case ({lo[0], q_1})
            2'b01:   booth_sum = hi + mcand_x;
            2'b10:   booth_sum = hi - mcand_x;
            default: booth_sum = hi;
        endcase
        mul_hi_nx = booth_sum >>> 1;
        mul_lo_nx = {booth_sum[0], lo[WIDTH-1:1]};
        mul_q1_nx = lo[0];
`endif
    end

    nr_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem     (hi),
        .quo     (lo),
        .divisor (opnd),
        .rem_nx  (div_rem_nx),
        .quo_nx  (div_quo_nx)
    );

    // Remainder add-back is applied on the final iteration's result, not in an extra cycle.
    always_comb begin
        div_d_x     = {2'b00, opnd};
        div_rem_mag = WIDTH'(div_rem_nx[WIDTH+1] ? (div_rem_nx + div_d_x) : div_rem_nx);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start)
                      state_nx = (bus.op == OP_DIV && bus.B == '0) ? DONE : RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= OP_MUL;
            a_neg <= 1'b0;
            b_neg <= 1'b0;
            q_1   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            zhigh <= '0;
            zlow  <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (bus.start) begin
                    op_r  <= bus.op;
                    cnt   <= '0;
                    dz    <= 1'b0;
                    q_1   <= 1'b0;
                    hi    <= '0;
                    a_neg <= bus.A[WIDTH-1];
                    b_neg <= bus.B[WIDTH-1];
                    if (bus.op == OP_DIV) begin
                        lo   <= abs_val(bus.A);
                        opnd <= abs_val(bus.B);
                        if (bus.B == '0) begin
                            dz    <= 1'b1;
                            zlow  <= WIDTH'(DIV0_QUOT);
                            zhigh <= bus.A;
                        end
                    end else begin
                        lo   <= bus.B;
                        opnd <= bus.A;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (op_r == OP_DIV) begin
                        hi <= div_rem_nx;
                        lo <= div_quo_nx;
                        if (last) begin
                            zlow  <= cond_neg(div_quo_nx, a_neg ^ b_neg);
                            zhigh <= cond_neg(div_rem_mag, a_neg);
                        end
                    end else begin
                        hi  <= mul_hi_nx;
                        lo  <= mul_lo_nx;
                        q_1 <= mul_q1_nx;
                        if (last) begin
                            zhigh <= mul_hi_nx[WIDTH-1:0];
                            zlow  <= mul_lo_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Zhigh    = zhigh;
    assign bus.Zlow     = zlow;
    assign bus.div_zero = dz;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed results and latencies.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int LAT_MUL = MUL_ITER + 1;
    localparam int LAT_DIV = DIV_ITER + 1;

    logic Clock = 1'b0;
    logic clear;
    int   n_cmp = 0;
    int   n_err = 0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one op in an IDLE cycle and waits (bounded) for done; lat counts the accepting edge as 1.
    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inject_at, output int lat, output bit busy_drop,
                          output logic [W-1:0] mid_hi, output logic [W-1:0] mid_lo);
        @(posedge Clock); #2;
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge Clock); #1;
        bus.start = 1'b0; bus.op = ~op; bus.A = 32'h5A5A5A5A; bus.B = 32'h3;
        lat = 1; busy_drop = 1'b0; mid_hi = '0; mid_lo = '0;
        while (!bus.done && lat < 200) begin
            if (!bus.busy) busy_drop = 1'b1;
            if (lat == 10) begin mid_hi = bus.Zhigh; mid_lo = bus.Zlow; end
            bus.start = (lat == inject_at);
            @(posedge Clock); #1;
            lat++;
        end
        bus.start = 1'b0;
        if (!bus.busy) busy_drop = 1'b1;
    endtask

    task automatic do_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inject_at, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dz, input int exp_lat);
        int lat; bit bd; logic [W-1:0] mh, ml;
        run_op(op, a, b, inject_at, lat, bd, mh, ml);
        check_val({tag, ".lat"},   64'(lat), 64'(exp_lat));
        check_val({tag, ".hi"},    64'(bus.Zhigh), 64'(exp_hi));
        check_val({tag, ".lo"},    64'(bus.Zlow), 64'(exp_lo));
        check_val({tag, ".dz"},    64'(bus.div_zero), 64'(exp_dz));
        check_val({tag, ".busy"},  64'(bd), 64'(0));
    endtask

    initial begin
        int lat; bit bd; logic [W-1:0] mh, ml;
        clear = 1'b0;
        bus.start = 1'b0; bus.op = OP_MUL; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_val("rst.hi",   64'(bus.Zhigh), 64'(0));
        check_val("rst.lo",   64'(bus.Zlow), 64'(0));
        check_val("rst.busy", 64'(bus.busy), 64'(0));
        check_val("rst.done", 64'(bus.done), 64'(0));
        check_val("rst.dz",   64'(bus.div_zero), 64'(0));
        @(negedge Clock); clear = 1'b1;

        do_op("mul7x-3", OP_MUL, 32'd7, 32'hFFFFFFFD, -1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, LAT_MUL);
        @(posedge Clock); #1;
        check_val("pulse.done", 64'(bus.done), 64'(0));
        check_val("pulse.busy", 64'(bus.busy), 64'(0));

        do_op("mulmin",  OP_MUL, 32'h80000000, 32'h80000000, -1, 32'h40000000, 32'h00000000, 1'b0, LAT_MUL);
        do_op("mulm1",   OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 32'h00000000, 32'h00000001, 1'b0, LAT_MUL);

        do_op("div-17/5", OP_DIV, 32'hFFFFFFEF, 32'd5, -1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, LAT_DIV);
        do_op("divovf",   OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV);
        do_op("div7/-2",  OP_DIV, 32'd7, 32'hFFFFFFFE, -1, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT_DIV);

        do_op("div0",     OP_DIV, 32'h12345678, 32'd0, -1, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1);
        do_op("div100/7", OP_DIV, 32'd100, 32'd7, -1, 32'd2, 32'd14, 1'b0, LAT_DIV);

        // Start issued in the IDLE cycle right after done; old result must hold mid-run.
        run_op(OP_MUL, 32'd7, 32'hFFFFFFFD, -1, lat, bd, mh, ml);
        check_val("b2b.lat",   64'(lat), 64'(LAT_MUL));
        check_val("b2b.midhi", 64'(mh), 64'(2));
        check_val("b2b.midlo", 64'(ml), 64'(14));
        check_val("b2b.lo",    64'(bus.Zlow), 64'(32'hFFFFFFEB));

        do_op("inject", OP_MUL, 32'd1000, 32'd2000, 10, 32'd0, 32'd2000000, 1'b0, LAT_MUL);

        @(posedge Clock); #2;
        bus.start = 1'b1; bus.op = OP_MUL; bus.A = 32'd9; bus.B = 32'd9;
        @(posedge Clock); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge Clock);
        #2; clear = 1'b0; #1;
        check_val("arst.busy", 64'(bus.busy), 64'(0));
        check_val("arst.done", 64'(bus.done), 64'(0));
        check_val("arst.hi",   64'(bus.Zhigh), 64'(0));
        check_val("arst.lo",   64'(bus.Zlow), 64'(0));
        @(negedge Clock); clear = 1'b1;

        do_op("mul3x4", OP_MUL, 32'd3, 32'd4, -1, 32'd0, 32'd12, 1'b0, LAT_MUL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
